// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: core data-port bus between the EX/MEM register and the data-memory stage
interface dmem_ctrl_if;
  logic        MemRead_l2;
  logic        MemWrite_l2;
  logic [1:0]  mem_size;
  logic [31:0] m_addr;
  logic [31:0] m_wr_dat;
  logic [31:0] m_rd_dat;
  modport master (output MemRead_l2, MemWrite_l2, mem_size, m_addr, m_wr_dat, input m_rd_dat);
  modport slave (input MemRead_l2, MemWrite_l2, mem_size, m_addr, m_wr_dat, output m_rd_dat);
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word RAM with byte-lane writes plus an mtime/mtimecmp timer and UART TX FIFO window
module dmem_ctrl #(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int          TICK_DIV   = 1,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  dmem_ctrl_if.slave  bus,
  output logic        timer_irq,
  output logic        misalign,
  output logic        bus_err,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [31:0] ram [DEPTH];
  logic [7:0] fifo [FIFO_DEPTH];
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [FW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, timer_irq_q, timer_irq_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [31:0] off, word, mmio_rd, wdat_sh;
  logic [3:0] be;
  logic [1:0] a;
  logic acc, is_word, mis, ram_hit, mmio_hit, unmapped, ok, wr_ok, rd_ok, mwr;
  logic tick, push, push_ok, pop, full, empty, stat_rd;
  always_comb begin
    a = bus.m_addr[1:0];
    acc = bus.MemRead_l2 | bus.MemWrite_l2;
    is_word = bus.mem_size[1];
    mis = is_word ? a != 2'b00 : bus.mem_size[0] & a[0];
    off = bus.m_addr - MMIO_BASE;
    ram_hit = (bus.m_addr >> (AW + 2)) == 32'd0;
    mmio_hit = off < 32'h14;
    unmapped = !(ram_hit | mmio_hit) | (mmio_hit & !is_word);
    ok = acc & !mis & !unmapped;
    wr_ok = ok & bus.MemWrite_l2;
    rd_ok = ok & bus.MemRead_l2 & !bus.MemWrite_l2;
    mwr = wr_ok & mmio_hit;
    word = ram[bus.m_addr[AW+1:2]];
    full = cnt_q == (FW+1)'(FIFO_DEPTH);
    empty = cnt_q == '0;
    mmio_rd = off[4] ? {24'd0, 4'(cnt_q), ovf_q, 1'b0, empty, full}
            : off[3] ? (off[2] ? mtimecmp_q[63:32] : mtimecmp_q[31:0])
            : (off[2] ? mtime_q[63:32] : mtime_q[31:0]);
    be = is_word ? 4'hF : bus.mem_size[0] ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
    wdat_sh = bus.m_wr_dat << {a, 3'b000};
    tick = presc_q == PW'(TICK_DIV - 1);
    presc_d = tick ? '0 : presc_q + 1'b1;
    mtime_d = (mwr && off[4:2] == 3'd0) ? {mtime_q[63:32], bus.m_wr_dat}
            : (mwr && off[4:2] == 3'd1) ? {bus.m_wr_dat, mtime_q[31:0]}
            : mtime_q + 64'(tick);
    mtimecmp_d = (mwr && off[4:2] == 3'd2) ? {mtimecmp_q[63:32], bus.m_wr_dat}
               : (mwr && off[4:2] == 3'd3) ? {bus.m_wr_dat, mtimecmp_q[31:0]}
               : mtimecmp_q;
    timer_irq_d = mtime_q >= mtimecmp_q;
    // A full FIFO still takes a push when the head leaves in the same cycle
    push = mwr & off[4];
    pop = !empty & uart_tx_ready;
    push_ok = push & (!full | pop);
    stat_rd = rd_ok & mmio_hit & off[4];
    wp_d = wp_q + FW'(push_ok);
    rp_d = rp_q + FW'(pop);
    cnt_d = cnt_q + (FW+1)'(push_ok) - (FW+1)'(pop);
    ovf_d = (ovf_q & !stat_rd) | (push & full & !pop);
    misalign_d = acc & mis;
    bus_err_d = acc & (unmapped | (bus.MemRead_l2 & bus.MemWrite_l2));
  end
  assign bus.m_rd_dat = !rd_ok ? 32'd0 : ram_hit ? word >> {a, 3'b000} : mmio_rd;
  assign timer_irq = timer_irq_q;
  assign misalign = misalign_q;
  assign bus_err = bus_err_q;
  assign uart_tx_valid = !empty;
  assign uart_tx_data = fifo[rp_q];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mtime_q <= '0;
      mtimecmp_q <= '1;
      presc_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      timer_irq_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q <= presc_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      timer_irq_q <= timer_irq_d;
      misalign_q <= misalign_d;
      bus_err_q <= bus_err_d;
    end
  always_ff @(posedge clk)
    if (wr_ok & ram_hit)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[bus.m_addr[AW+1:2]][8*i +: 8] <= wdat_sh[8*i +: 8];
  always_ff @(posedge clk)
    if (push_ok) fifo[wp_q] <= bus.m_wr_dat[7:0];
endmodule
